// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame controller upstream of the Serializer
//
// Purpose:
//   Latches a parallel byte on request and runs one UART frame (start, data, optional
//   parity, stop bits). It enables the Serializer for the start and data bits and muxes
//   the start, data, parity and stop levels onto TX_OUT. One bit is sent per CLK cycle,
//   because CLK is the baud-tick clock. The Serializer's ser_done handshake is checked;
//   any deviation pulses ser_err.
//
// Configuration macro:
//   UART_TX_PARITY_EN  When defined, the PAR_TYP port and the PARITY state are present.
//                      When undefined, frames go straight from DATA to STOP.
//
// Parameters:
//   DATA_WIDTH  payload bits per frame (must match the Serializer width)
//   STOP_BITS   stop bits per frame, 1 or 2
//
// Ports:
//   CLK         in   clock, rising edge (baud tick)
//   RST         in   reset, asynchronous, active-low
//   P_DATA      in   byte to transmit
//   DATA_VALID  in   send request, honoured in IDLE and on the last stop cycle
//   PAR_TYP     in   0 = even parity, 1 = odd (UART_TX_PARITY_EN only)
//   ser_data    in   serial bit from the Serializer (registered there)
//   ser_done    in   Serializer completion pulse
//   ser_in      out  latched byte to the Serializer's parallel input
//   ser_en      out  Serializer enable (START and DATA)
//   TX_OUT      out  UART line, idles high
//   BUSY        out  frame in progress
//   ser_err     out  one-cycle pulse on a ser_done handshake violation

module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_TYP,
`endif
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic [DATA_WIDTH-1:0] ser_in,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  ser_err
);

  // Only one- and two-stop-bit frames are supported; anything else must not build.
  generate
    if (!(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_stop_bits
      $error("uart_tx_frame_ctrl: STOP_BITS must be 1 or 2");
    end
  endgenerate

  // bit_cnt indexes data bits and stop bits; data bits need the wider range.
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   ser_in_d;
  logic                    ser_err_d;
  logic                    load;
  logic                    done_slot;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ser_in    <= '0;
      ser_err   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ser_in    <= ser_in_d;
      ser_err   <= ser_err_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ser_in_d  = ser_in;
    load      = 1'b0;
    done_slot = 1'b0;
    ser_en    = 1'b0;
    TX_OUT    = 1'b1;
    BUSY      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        BUSY = 1'b0;
        if (DATA_VALID) begin
          load    = 1'b1;
          state_d = START;
        end
      end

      START: begin
        TX_OUT    = 1'b0;
        ser_en    = 1'b1;
        bit_cnt_d = '0;
        state_d   = DATA;
      end

      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
        if (bit_cnt_q == DATA_LAST) begin
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d   = PARITY;
`else
          state_d   = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        TX_OUT    = parity_q;
        // The Serializer reports completion in the cycle right after the last data bit.
        done_slot = 1'b1;
        state_d   = STOP;
      end
`endif

      STOP: begin
        TX_OUT = 1'b1;
`ifndef UART_TX_PARITY_EN
        // Without a parity bit the completion slot is the first stop cycle.
        done_slot = (bit_cnt_q == '0);
`endif
        if (bit_cnt_q == STOP_LAST) begin
          bit_cnt_d = '0;
          // A request on the last stop cycle chains the next frame with no idle gap.
          if (DATA_VALID) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      default: begin
        BUSY    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (load) begin
      ser_in_d = P_DATA;
`ifdef UART_TX_PARITY_EN
      // Even parity is the XOR of the payload; odd parity is its complement.
      parity_d = (^P_DATA) ^ PAR_TYP;
`endif
    end

    // ser_done must be high in the completion slot and low everywhere else.
    ser_err_d = ser_done ^ done_slot;
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - scoreboard testbench for uart_tx_frame_ctrl
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;
  localparam int SB = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 1 + DW + PB + SB;

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   bits;
  } frame_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          par_typ = 1'b0;
  logic          ser_data;
  logic          ser_done;
  logic [DW-1:0] ser_in;
  logic          ser_en;
  logic          TX_OUT;
  logic          BUSY;
  logic          ser_err;

  logic          s_done;
  logic          s_act;
  int            s_idx;
  logic          inj_done = 1'b0;

  int checks = 0;
  int failures = 0;
  frame_t exp_q[$];
  int left = 0;
  int frames_exp = 0;
  int frames_seen = 0;
  int aborted = 0;
  int exp_err = 0;
  int err_seen = 0;

  bit     mon_active = 1'b0;
  int     mon_pos = 0;
  frame_t cur;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
`ifdef UART_TX_PARITY_EN
    .PAR_TYP    (par_typ),
`endif
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .ser_err    (ser_err)
  );

  // Behavioural Serializer: loads on the first enabled edge, shifts LSB first,
  // and pulses done in the cycle after its last bit has been on the line.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_act    <= 1'b0;
      s_idx    <= 0;
      ser_data <= 1'b0;
      s_done   <= 1'b0;
    end else begin
      s_done <= 1'b0;
      if (ser_en) begin
        if (!s_act) begin
          s_act    <= 1'b1;
          s_idx    <= 0;
          ser_data <= ser_in[0];
        end else if (s_idx == DW - 1) begin
          s_act  <= 1'b0;
          s_done <= 1'b1;
        end else begin
          s_idx    <= s_idx + 1;
          ser_data <= ser_in[s_idx + 1];
        end
      end
    end
  end

  assign ser_done = s_done | inj_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, then stop ones.
  function automatic frame_t make_frame(input logic [DW-1:0] d, input logic pt);
    frame_t f;
    int ones;
    f.data = d;
    f.bits = '1;
    f.bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      f.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    f.bits[1 + DW] = ((ones % 2) == 1) ? ~pt : pt;
`else
    if (pt && ones < 0) f.bits[0] = 1'b1;
`endif
    return f;
  endfunction

  // One cycle of stimulus, driven just after the rising edge. The model accepts a
  // request when idle (left==0) or on the last stop cycle (left==1).
  task automatic cyc(input logic dv, input logic [DW-1:0] d, input logic pt, input logic inj);
    int left_n;
    DATA_VALID = dv;
    P_DATA     = d;
    par_typ    = pt;
    inj_done   = inj;
    if (inj) exp_err++;
    if (dv && left <= 1) begin
      exp_q.push_back(make_frame(d, pt));
      frames_exp++;
      left_n = FL;
    end else begin
      left_n = (left > 0) ? left - 1 : 0;
    end
    @(posedge CLK);
    #1;
    left = left_n;
    inj_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  // DATA cycles carry left values FL-1 .. FL-DW.
  function automatic bit in_data(input int l);
    return (l <= FL - 1) && (l >= FL - DW);
  endfunction

  // Monitor: frames are recognised from BUSY; each one pops its expectation at START.
  always @(negedge CLK) begin
    if (!RST) begin
      mon_active <= 1'b0;
      mon_pos    <= 0;
    end else begin
      if (ser_err) err_seen++;
      if (!mon_active && !BUSY) begin
        chk("idle_tx_out", 32'(TX_OUT), 32'd1);
        chk("idle_ser_en", 32'(ser_en), 32'd0);
      end else begin
        frame_t f;
        int p;
        if (!mon_active) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame busy=1 required_busy=0 t=%0t", $time);
            f.data = ser_in;
            f.bits = '1;
          end else begin
            f = exp_q.pop_front();
          end
          p = 0;
        end else begin
          f = cur;
          p = mon_pos;
        end
        chk("busy", 32'(BUSY), 32'd1);
        chk("tx_bit", 32'(TX_OUT), 32'(f.bits[p]));
        chk("ser_en", 32'(ser_en), (p <= DW) ? 32'd1 : 32'd0);
        chk("ser_in", 32'(ser_in), 32'(f.data));
        cur <= f;
        if (p == FL - 1) begin
          mon_active <= 1'b0;
          mon_pos    <= 0;
          frames_seen++;
        end else begin
          mon_active <= 1'b1;
          mon_pos    <= p + 1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx_out", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ser_en", 32'(ser_en), 32'd0);
    chk("rst_ser_err", 32'(ser_err), 32'd0);
    chk("rst_ser_in", 32'(ser_in), 32'd0);
    RST = 1'b1;
    idle(2);

    // Single frames with both parity types.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(FL + 2);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    idle(FL + 2);

    // Request held high: second frame chains onto the last stop cycle.
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < FL; i++) cyc(1'b1, 8'h0F, 1'b1, 1'b0);
    idle(FL + 2);

    // A request during DATA is dropped and the in-flight byte is kept.
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    idle(FL + 2);

    // Spurious ser_done during a data bit.
    cyc(1'b1, 8'h96, 1'b1, 1'b0);
    for (int i = 0; i < FL + 2; i++) cyc(1'b0, '0, 1'b0, (left == FL - 3));

    // Reset during data bit 3 aborts the frame at once.
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    while (left != FL - 4) cyc(1'b0, '0, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    chk("abort_tx_out", 32'(TX_OUT), 32'd1);
    chk("abort_ser_en", 32'(ser_en), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    aborted++;
    @(posedge CLK);
    #1;
    RST  = 1'b1;
    left = 0;
    cyc(1'b1, 8'h81, 1'b1, 1'b0);
    idle(FL + 2);

    // Randomised traffic with occasional handshake faults.
    for (int i = 0; i < 400; i++) begin
      logic dv;
      logic inj;
      dv  = ($urandom_range(0, 3) == 0);
      inj = in_data(left) && ($urandom_range(0, 19) == 0);
      cyc(dv, DW'($urandom), 1'($urandom), inj);
    end

    // Drain, bounded.
    for (int i = 0; i < 4 * FL && (exp_q.size() != 0 || mon_active || left != 0); i++) idle(1);
    idle(3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frames_seen", 32'(frames_seen), 32'(frames_exp - aborted));
    chk("ser_err_pulses", 32'(err_seen), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
